// File: rtl/weight_bank_pingpong.sv
// weight_bank_pingpong
//   Double-buffered weight store for the systolic array. The host writes the
//   shadow bank one word per cycle while a burst streamer reads LANES
//   consecutive words per beat from the active bank. A swap exchanges the
//   two banks once no burst is in progress.
//
// Ports
//   clk_i          system clock, all state on the rising edge
//   reset_ni       asynchronous active-low reset
//   wr_en_i        write strobe into the shadow bank
//   wr_addr_i      shadow-bank word address
//   wr_data_i      write data
//   swap_req_i     request to exchange active/shadow banks (pulse)
//   swap_done_o    one-cycle pulse after the edge the swap executes on
//   active_bank_o  bank currently read by the streamer
//   rd_start_i     start a burst (only honoured while idle)
//   rd_base_i      first word address of the burst
//   rd_count_i     number of beats in the burst
//   busy_o         burst in progress
//   out_valid_o    beat valid
//   out_ready_i    consumer accepts beat
//   out_data_o     lane i at bits [i*DATA_W +: DATA_W]
//   out_last_o     final beat of the burst
//
// States
//   S_IDLE   | no burst; accepts rd_start and executes swaps
//   S_STREAM | burst in progress; beats loaded from the active bank

module weight_bank_pingpong #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int LANES  = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 8
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [DATA_W-1:0]       wr_data_i,
  input  logic                    swap_req_i,
  output logic                    swap_done_o,
  output logic                    active_bank_o,
  input  logic                    rd_start_i,
  input  logic [ADDR_W-1:0]       rd_base_i,
  input  logic [CNT_W-1:0]        rd_count_i,
  output logic                    busy_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [LANES*DATA_W-1:0] out_data_o,
  output logic                    out_last_o
);

  typedef enum logic {S_IDLE = 1'b0, S_STREAM = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic                    active_q;
  logic                    pending_q;
  logic                    swap_done_q;
  logic [ADDR_W-1:0]       addr_q;
  logic [CNT_W-1:0]        remaining_q;
  logic                    out_valid_q;
  logic                    out_last_q;
  logic [LANES*DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0]       mem_q [2][DEPTH];

  logic                    start_ok;
  logic                    load;
  logic                    accept;
  logic                    swap_exec;
  logic [LANES*DATA_W-1:0] lanes;

  assign start_ok  = (state_q == S_IDLE) && rd_start_i && (rd_count_i != '0);
  assign load      = (state_q == S_STREAM) && (remaining_q != '0) &&
                     (!out_valid_q || out_ready_i);
  assign accept    = out_valid_q && out_ready_i;
  // Swaps only execute while idle, so a burst always sees one bank. When a
  // swap and an accepted start coincide, the first beat is loaded a cycle
  // later from active_q, which by then already holds the new bank.
  assign swap_exec = (state_q == S_IDLE) && (swap_req_i || pending_q);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_ok) state_d = S_STREAM;
      // Last beat accepted: remaining is already zero, so nothing reloads.
      S_STREAM: if (accept && out_last_q && !load) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    if (state_q == S_STREAM) busy_o = 1'b1;
  end

  // ------------------------------------------------------ bank storage
  // Writes target the bank that is shadow before this edge, even if a swap
  // makes it active on the same edge.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[~active_q][wr_addr_i] <= wr_data_i;
  end

  // Lane addresses wrap naturally because DEPTH is a power of two.
  always_comb begin
    logic [ADDR_W-1:0] lane_addr;
    lanes     = '0;
    lane_addr = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_addr = addr_q + ADDR_W'(i);
      lanes[i*DATA_W +: DATA_W] = mem_q[active_q][lane_addr];
    end
  end

  // ------------------------------------------------ swap and streaming
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      swap_done_q <= 1'b0;
      addr_q      <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      swap_done_q <= swap_exec;
      if (swap_exec) begin
        active_q  <= ~active_q;
        pending_q <= 1'b0;
      end else if (swap_req_i) begin
        pending_q <= 1'b1;
      end

      if (start_ok) begin
        addr_q      <= rd_base_i;
        remaining_q <= rd_count_i;
      end

      if (load) begin
        addr_q      <= addr_q + ADDR_W'(LANES);
        remaining_q <= remaining_q - CNT_W'(1);
        out_data_q  <= lanes;
        out_last_q  <= (remaining_q == CNT_W'(1));
        out_valid_q <= 1'b1;
      end else if (accept) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign swap_done_o   = swap_done_q;
  assign active_bank_o = active_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_last_o    = out_last_q;

endmodule
